// File: rtl/bp_pkg.sv
// Shared definitions for the branch-direction predictor.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bp_pkg;

    // 2-bit saturating counter states. The prediction is bit [1].
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Default number of PC index bits (table holds 2^IDX_W counters).
    localparam int BP_IDX_W_DEF = 6;

    // Table index of a PC: word address with the byte-offset bits dropped,
    // masked to idx_w bits. No tag is kept, so different PCs can alias.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input int idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of one 2-bit saturating direction counter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; when en is low the state passes through unchanged.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    input  logic       en,
    output logic [1:0] next_state
);

    // Step toward ST on taken, toward SNT on not-taken, clamping at the ends.
    always_comb begin
        next_state = state;
        if (en) begin
            if (taken) begin
                if (state != ST) begin
                    next_state = state + 2'd1;
                end
            end else begin
                if (state != SNT) begin
                    next_state = state - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch-direction predictor (2-bit counters, untagged); optional stats via BP_STATS_EN.
// Latency: prediction combinational from f_pc; training written on the qualifying clock edge.
// Backpressure: never stalls the pipeline; d_stall holds off the update for every stalled cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      f_pc,
    output logic             f_pred_taken,
    input  logic             d_valid,
    input  logic             d_stall,
    input  logic [31:0]      d_pc,
    input  logic             d_taken,
    input  logic             d_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic [1:0]       tbl [ENTRIES];
    logic             upd;
    logic [1:0]       cur_state;
    logic [1:0]       nxt_state;

    assign f_idx = IDX_W'(bp_index(f_pc, IDX_W));
    assign d_idx = IDX_W'(bp_index(d_pc, IDX_W));

    // Read port: no bypass, so a same-cycle update to this index is not seen yet.
    assign f_pred_taken = tbl[f_idx][1];

    // A branch trains exactly once: on the cycle it is valid and not stalled.
    assign upd        = d_valid & ~d_stall;
    assign mispredict = upd & (d_taken ^ d_pred);

    assign cur_state = tbl[d_idx];

    bp_sat_counter u_sat_counter (
        .state      (cur_state),
        .taken      (d_taken),
        .en         (upd),
        .next_state (nxt_state)
    );

    // Counter table as flops so every entry can reset asynchronously to WNT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= WNT;
            end
        end else if (upd) begin
            tbl[d_idx] <= nxt_state;
        end
    end

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    // Retired-branch and misprediction counts, each saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (upd && (br_cnt != '1)) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (mispredict && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

    assign stat_branches = br_cnt;
    assign stat_mispred  = mis_cnt;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed literal checks plus random traffic.
// Latency: outputs compared every negedge against a behavioural model.
// Backpressure: random d_stall exercises the update hold-off.
module tb_branch_predictor;

    localparam int IDX_W   = 6;
    localparam int CNT_W   = 4;
    localparam int ENTRIES = 64;
    localparam int CNT_MAX = 15;
`ifdef BP_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      f_pc = 32'h0;
    logic             f_pred_taken;
    logic             d_valid = 1'b0;
    logic             d_stall = 1'b0;
    logic [31:0]      d_pc = 32'h0;
    logic             d_taken = 1'b0;
    logic             d_pred = 1'b0;
    logic             mispredict;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b0;

    // Behavioural model: counter strength 0..3 per entry, plain integer counts.
    int mdl_cnt [ENTRIES];
    int mdl_br;
    int mdl_mis;

    branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .f_pc          (f_pc),
        .f_pred_taken  (f_pred_taken),
        .d_valid       (d_valid),
        .d_stall       (d_stall),
        .d_pc          (d_pc),
        .d_taken       (d_taken),
        .d_pred        (d_pred),
        .mispredict    (mispredict),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state follows the spec rules: reset to WNT, +/-1 clamped to 0..3.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) mdl_cnt[i] <= 1;
            mdl_br  <= 0;
            mdl_mis <= 0;
        end else if (d_valid && !d_stall) begin
            if (d_taken) mdl_cnt[idx_of(d_pc)] <= (mdl_cnt[idx_of(d_pc)] < 3) ? mdl_cnt[idx_of(d_pc)] + 1 : 3;
            else         mdl_cnt[idx_of(d_pc)] <= (mdl_cnt[idx_of(d_pc)] > 0) ? mdl_cnt[idx_of(d_pc)] - 1 : 0;
            if (mdl_br < CNT_MAX) mdl_br <= mdl_br + 1;
            if (d_taken != d_pred && mdl_mis < CNT_MAX) mdl_mis <= mdl_mis + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("pred", {31'd0, f_pred_taken}, {31'd0, mdl_cnt[idx_of(f_pc)] >= 2});
            chk("mispredict", {31'd0, mispredict},
                {31'd0, d_valid && !d_stall && (d_taken != d_pred)});
            chk("stat_branches", 32'(stat_branches), STATS_ON ? 32'(mdl_br) : 32'd0);
            chk("stat_mispred", 32'(stat_mispred), STATS_ON ? 32'(mdl_mis) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string name, input logic [31:0] pc, input bit exp);
        f_pc = pc;
        #1;
        chk(name, {31'd0, f_pred_taken}, {31'd0, exp});
    endtask

    task automatic do_upd(input logic [31:0] pc, input bit tk, input bit pr, input bit exp_mis);
        d_valid = 1'b1;
        d_stall = 1'b0;
        d_pc    = pc;
        d_taken = tk;
        d_pred  = pr;
        #1;
        chk("mispredict_lit", {31'd0, mispredict}, {31'd0, exp_mis});
        tick();
        d_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        tick();
        tick();
        run_chk = 1'b1;
        reset_n = 1'b1;
        tick();

        // Reset then read
        peek("reset_pred", 32'h0000_3000, 1'b0);
        tick();

        // Saturation up at 0x3010
        do_upd(32'h3010, 1'b1, 1'b0, 1'b1);
        do_upd(32'h3010, 1'b1, 1'b1, 1'b0);
        peek("sat_up_2", 32'h3010, 1'b1);
        do_upd(32'h3010, 1'b1, 1'b1, 1'b0);
        do_upd(32'h3010, 1'b0, 1'b1, 1'b1);
        peek("sat_up_st_nt", 32'h3010, 1'b1);
        tick();

        // Saturation down at 0x3020
        do_upd(32'h3020, 1'b0, 1'b0, 1'b0);
        do_upd(32'h3020, 1'b0, 1'b0, 1'b0);
        do_upd(32'h3020, 1'b0, 1'b0, 1'b0);
        do_upd(32'h3020, 1'b1, 1'b0, 1'b1);
        peek("sat_down", 32'h3020, 1'b0);
        tick();

        // Stall suppresses mispredict and the update
        d_valid = 1'b1; d_stall = 1'b1; d_pc = 32'h3030; d_taken = 1'b1; d_pred = 1'b0;
        #1;
        chk("stall_mispredict", {31'd0, mispredict}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        d_valid = 1'b0; d_stall = 1'b0;
        peek("stall_no_update", 32'h3030, 1'b0);
        tick();

        // Aliasing and same-cycle read: 0x3004 and 0x3104 share index 1
        f_pc = 32'h3104;
        d_valid = 1'b1; d_pc = 32'h3004; d_taken = 1'b1; d_pred = 1'b0;
        #1;
        chk("alias_old", {31'd0, f_pred_taken}, 32'd0);
        tick();
        d_valid = 1'b0;
        peek("alias_new", 32'h3104, 1'b1);
        tick();

        // Mid-run reset restores WNT and clears the statistics
        reset_n = 1'b0;
        peek("rst_pred", 32'h3010, 1'b0);
        chk("rst_stat_br", 32'(stat_branches), 32'd0);
        chk("rst_stat_mis", 32'(stat_mispred), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Statistics: 10 updates, 3 mispredicts
        for (int i = 0; i < 10; i++) begin
            do_upd(32'h3100 + 32'(i * 4), 1'b1, (i < 3) ? 1'b0 : 1'b1, (i < 3) ? 1'b1 : 1'b0);
        end
        chk("stat_br_10", 32'(stat_branches), STATS_ON ? 32'd10 : 32'd0);
        chk("stat_mis_3", 32'(stat_mispred), STATS_ON ? 32'd3 : 32'd0);
        // 10 more, all mispredicted: branches saturate at 15
        for (int i = 0; i < 10; i++) do_upd(32'h3200, 1'b0, 1'b1, 1'b1);
        chk("stat_br_sat", 32'(stat_branches), STATS_ON ? 32'd15 : 32'd0);
        chk("stat_mis_13", 32'(stat_mispred), STATS_ON ? 32'd13 : 32'd0);
        for (int i = 0; i < 5; i++) do_upd(32'h3200, 1'b1, 1'b0, 1'b1);
        chk("stat_mis_sat", 32'(stat_mispred), STATS_ON ? 32'd15 : 32'd0);

        // Random traffic over 128 words so entries alias; occasional async resets
        for (int c = 0; c < 3000; c++) begin
            f_pc    = 32'h3000 + (32'($urandom_range(0, 127)) << 2);
            d_pc    = 32'h3000 + (32'($urandom_range(0, 127)) << 2) + 32'($urandom_range(0, 3));
            d_valid = ($urandom_range(0, 3) != 0);
            d_stall = ($urandom_range(0, 3) == 0);
            d_taken = $urandom_range(0, 1) != 0;
            d_pred  = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                #3 reset_n = 1'b1;
            end
            tick();
        end

        d_valid = 1'b0;
        tick();
        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch-direction predictor for the five-stage MIPS pipeline. It consumes the branch condition produced in the D stage, O[0] for the BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ comparator types, and trains a table of 2-bit saturating counters. It also supplies a taken/not-taken guess to the F stage for the next fetch. It is the reader side of the compare-result interface: the comparator writes a branch outcome, and this block records it and flags mispredictions to the NPC logic.

## Interface
Parameters:
- IDX_W, 6, number of PC index bits; the table holds 2^IDX_W counters.
- CNT_W, 32, width of the statistics counters (used only with BP_STATS_EN).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- f_pc  input  32  F-stage PC to predict
- f_pred_taken  output  1  prediction for f_pc; combinational read of the table
- d_valid  input  1  D stage holds a conditional branch whose comparator result is final
- d_stall  input  1  D stage is stalled; suppresses the update
- d_pc  input  32  PC of the D-stage branch
- d_taken  input  1  comparator outcome (O[0])
- d_pred  input  1  prediction carried down the pipeline with the branch
- mispredict  output  1  combinational: d_valid & ~d_stall & (d_taken != d_pred)
- stat_branches  output  CNT_W  retired-branch count (BP_STATS_EN only)
- stat_mispred  output  CNT_W  misprediction count (BP_STATS_EN only)

## Operation
- Index is pc[IDX_W+1:2]; the low two bits are ignored. There are no tags, so aliasing is permitted.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. Prediction is counter[1].
- Update fires when d_valid=1 and d_stall=0. On an update the indexed counter moves:
  - taken: +1, saturating at ST.
  - not-taken: −1, saturating at SNT.
- Transitions:
  - SNT: taken→WNT, not-taken stays SNT.
  - WNT: taken→WT, not-taken→SNT.
  - WT: taken→ST, not-taken→WNT.
  - ST: taken stays ST, not-taken→WT.
- When d_stall=1, nothing changes, mispredict=0, and the statistics hold. Hold-off is repeated for every stalled cycle, so each branch updates exactly once.
- Reset (any time, including mid-update): every counter goes to WNT, and both statistics counters and all registered state go to 0. f_pred_taken reads 0 after reset. mispredict has no state; it follows its inputs.
- Simultaneous read and update of the same index: f_pred_taken returns the pre-update value. There is no bypass.
- No other state exists. The block never stalls the pipeline.

## Timing
- Prediction: zero latency, combinational from f_pc.
- Update: written on the rising clk edge of the qualifying cycle; visible to f_pred_taken from the next cycle.
- mispredict is valid in the same cycle as d_valid. The NPC logic redirects on it.
- Statistics update on the same edge as the table.
- stat_branches increments on each qualifying update.
- stat_mispred increments when a qualifying update also mispredicts.
- Both statistics counters saturate at all-ones and never wrap.

## Configuration
- BP_STATS_EN defined: the statistics counters are built, and stat_branches/stat_mispred report the counts above.
- BP_STATS_EN undefined: no counter flops are built, and stat_branches/stat_mispred are tied to 0.
- The prediction and update behaviour is identical either way.

## Structure
- Shared package bp_pkg holds:
  - the counter-state localparams SNT/WNT/WT/ST;
  - the default IDX_W;
  - an index-extraction function.
- Sub-module bp_sat_counter is natural: it holds the pure next-state function (state, taken, en → next state). It is instantiated once on the update path.
- The table is a flop array, not RAM, because it needs asynchronous reset to WNT.

## Test plan
- Reset then read: release reset_n, f_pc=0x0000_3000 → f_pred_taken=0. Assert reset_n=0 mid-run after training → all entries return to WNT and the statistics return to 0.
- Saturation up: two taken updates at d_pc=0x3010 (d_pred=0, then 1) → f_pred_taken=1 at 0x3010. A third taken update leaves it at ST, and one not-taken update still predicts 1.
- Saturation down: from WNT, three not-taken updates at 0x3020 → SNT. One taken update → still predicts 0.
- Mispredict: d_valid=1, d_taken=1, d_pred=0 → mispredict=1 in the same cycle. With d_stall=1 and the same inputs → mispredict=0 and the counter is unchanged.
- Aliasing and same-cycle read: d_pc=0x3004 updates while f_pc=0x3104 (same index at IDX_W=6) → the prediction that cycle shows the old value and the next cycle shows the new value.
- Stats (BP_STATS_EN): 10 updates with 3 mispredicts → stat_branches=10, stat_mispred=3. With CNT_W=4 and 20 updates → stat_branches=15, held at saturation.
